// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit code table, decoder FSM states, digit tags
// and the per-beat decode payload. Also used by the accumulator's display path.
package seg7_pkg;

  localparam int unsigned SEG_W      = 7;   // segment code width, bit6=a .. bit0=g
  localparam int unsigned DIG_W      = 4;   // decoded BCD digit width
  localparam int unsigned VAL_W      = 7;   // width of tens*10+ones (max 99)
  localparam int unsigned NUM_DIGITS = 10;

  // Lit-segment codes for digits 0..9
  localparam logic [SEG_W-1:0] SEG7_LUT [NUM_DIGITS] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
  };

  typedef enum logic [1:0] {
    EXP_TENS = 2'd0,
    EXP_ONES = 2'd1,
    HOLD     = 2'd2
  } state_t;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_t;

  // Result of decoding one segment code
  typedef struct packed {
    logic [DIG_W-1:0] digit;  // 0..9, zero when bad
    logic             bad;    // code not in SEG7_LUT
  } dig_dec_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational 7-segment code to digit decoder.
// Ports:
//   code   in   7-bit segment code (bit6=a .. bit0=g)
//   dec_c  out  decoded digit plus illegal-code flag (digit forced 0 when illegal)
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] code,
  output dig_dec_t         dec_c
);

  // Table search: exactly one entry can match since all codes are distinct
  always_comb begin
    dec_c.digit = '0;
    dec_c.bad   = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (code == SEG7_LUT[i]) begin
        dec_c.digit = DIG_W'(i);
        dec_c.bad   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_pair_decoder.sv
// Decodes a stream of digit-tagged 7-segment codes (tens then ones) into a
// binary value 0..99 presented on a valid/ready output with an illegal-code flag.
// Optional build macro: SEG_STABLE_EN -- a beat only reaches the pair FSM after
// STABLE_N consecutive identical accepted beats.
// Ports:
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   s_data         segment code, bit6=a..bit0=g
//   s_digit        0 = ones digit, 1 = tens digit
//   s_valid/ready  input handshake; s_ready depends on state only
//   m_data         tens*10+ones, zero when m_err
//   m_err          a digit code of the pair was illegal
//   m_valid/ready  output handshake; data held stable while m_valid
//   seq_drop_cnt   saturating count of out-of-order beats discarded
module seg7_pair_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned W        = 7,
  parameter int unsigned STABLE_N = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [SEG_W-1:0] s_data,
  input  logic             s_digit,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [W-1:0]     m_data,
  output logic             m_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] seq_drop_cnt
);

  // Elaboration-time parameter sanity
  if (W < SEG_W || STABLE_N < 1 || CNT_W < 1) begin : g_param_bad
    $error("seg7_pair_decoder: need W >= 7, STABLE_N >= 1, CNT_W >= 1");
  end

  state_t           state_q;
  state_t           state_d;
  logic [DIG_W-1:0] tens_q;
  logic             tens_bad_q;
  dig_dec_t         dec_c;
  logic             accept_c;
  logic             beat_c;
  logic             is_tens_c;
  logic             latch_tens_c;
  logic             drop_c;
  logic             emit_c;
  logic             release_c;
  logic [VAL_W-1:0] sum_c;
  logic             pair_bad_c;

  assign s_ready   = (state_q != HOLD);
  assign accept_c  = s_valid & s_ready;
  assign is_tens_c = (s_digit == logic'(DIG_TENS));

`ifdef SEG_STABLE_EN
  // Stability filter: counts consecutive identical accepted beats and passes
  // the beat that completes a run of STABLE_N, then starts a fresh run.
  localparam int unsigned MATCH_W = $clog2(STABLE_N + 1);

  logic [SEG_W:0]     last_q;
  logic [MATCH_W-1:0] match_q;
  logic [MATCH_W-1:0] match_nxt_c;

  always_comb begin
    match_nxt_c = MATCH_W'(1);
    if (match_q != '0 && last_q == {s_digit, s_data}) begin
      match_nxt_c = match_q + MATCH_W'(1);
    end
  end

  assign beat_c = accept_c && (match_nxt_c == MATCH_W'(STABLE_N));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q  <= '0;
      match_q <= '0;
    end else if (accept_c) begin
      last_q  <= {s_digit, s_data};
      match_q <= beat_c ? '0 : match_nxt_c;
    end
  end
`else
  assign beat_c = accept_c;
`endif

  // Single decoder shared by tens and ones beats; only the current beat is decoded
  seg7_digit_decode u_dec (
    .code  (s_data),
    .dec_c (dec_c)
  );

  // Pair value at 7 bits; tens_q <= 9 so the result never exceeds 99
  assign sum_c      = VAL_W'(tens_q) * VAL_W'(10) + VAL_W'(dec_c.digit);
  assign pair_bad_c = tens_bad_q | dec_c.bad;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EXP_TENS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d      = state_q;
    latch_tens_c = 1'b0;
    drop_c       = 1'b0;
    emit_c       = 1'b0;
    release_c    = 1'b0;
    unique case (state_q)
      EXP_TENS: begin
        if (beat_c) begin
          if (is_tens_c) begin
            latch_tens_c = 1'b1;
            state_d      = EXP_ONES;
          end else begin
            drop_c = 1'b1;
          end
        end
      end
      EXP_ONES: begin
        if (beat_c) begin
          if (is_tens_c) begin
            // a second tens beat supersedes the first one
            latch_tens_c = 1'b1;
            drop_c       = 1'b1;
          end else begin
            emit_c  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          release_c = 1'b1;
          state_d   = EXP_TENS;
        end
      end
      default: begin
        state_d = EXP_TENS;
      end
    endcase
  end

  // Stored tens digit, output register and drop counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tens_q       <= '0;
      tens_bad_q   <= 1'b0;
      m_data       <= '0;
      m_err        <= 1'b0;
      m_valid      <= 1'b0;
      seq_drop_cnt <= '0;
    end else begin
      if (latch_tens_c) begin
        tens_q     <= dec_c.digit;
        tens_bad_q <= dec_c.bad;
      end
      if (emit_c) begin
        m_data  <= pair_bad_c ? '0 : W'(sum_c);
        m_err   <= pair_bad_c;
        m_valid <= 1'b1;
      end else if (release_c) begin
        m_valid <= 1'b0;
      end
      if (drop_c && seq_drop_cnt != '1) begin
        seq_drop_cnt <= seq_drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Self-checking bench for seg7_pair_decoder: hand sequences, a pair table and
// a randomized stream scored against a digit-pair reference model.
module tb_seg7_pair_decoder;

  localparam int unsigned W        = 7;
  localparam int unsigned STABLE_N = 3;
  localparam int unsigned CNT_W    = 8;
`ifdef SEG_STABLE_EN
  localparam int REP = STABLE_N;
`else
  localparam int REP = 1;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [6:0]       s_data = '0;
  logic             s_digit = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [W-1:0]     m_data;
  logic             m_err;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [CNT_W-1:0] seq_drop_cnt;

  seg7_pair_decoder #(.W(W), .STABLE_N(STABLE_N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_data       (s_data),
    .s_digit      (s_digit),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_err        (m_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .seq_drop_cnt (seq_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Digit code table, independent copy
  logic [6:0] codes [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  function automatic int dec(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  // Reference model: pending tens digit, drop tally, queue of expected outputs
  typedef struct { int data; bit err; } out_t;
  out_t exp_q[$];
  bit   mdl_have;
  int   mdl_tens;
  bit   mdl_tbad;
  int   mdl_drops;

  function automatic void model_beat(input bit d, input logic [6:0] c);
    int v;
    out_t o;
    v = dec(c);
    if (d) begin
      if (mdl_have) mdl_drops++;
      mdl_have = 1'b1;
      mdl_tbad = (v < 0);
      mdl_tens = (v < 0) ? 0 : v;
    end else if (!mdl_have) begin
      mdl_drops++;
    end else begin
      o.err  = mdl_tbad || (v < 0);
      o.data = o.err ? 0 : mdl_tens * 10 + v;
      exp_q.push_back(o);
      mdl_have = 1'b0;
    end
  endfunction

  function automatic int sat_drops();
    return (mdl_drops > CNT_MAX) ? CNT_MAX : mdl_drops;
  endfunction

  // One accepted handshake; returns at accepting edge + 1
  task automatic send_raw(input bit d, input logic [6:0] c, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_digit = d;
    s_data  = c;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = s_ready;
    if (!ok) begin
      check("s_ready_timeout", int'(s_ready), 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Logical beat: repeated so it passes the stability filter when enabled
  task automatic send(input bit d, input logic [6:0] c);
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    for (int r = 0; r < REP; r++) begin
      send_raw(d, c, ok);
      all_ok = all_ok & ok;
    end
    if (all_ok) model_beat(d, c);
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    check({name, "_valid_drop"}, int'(m_valid), 0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    mdl_have  = 1'b0;
    mdl_tens  = 0;
    mdl_tbad  = 1'b0;
    mdl_drops = 0;
    exp_q.delete();
  endtask

  // Random consumer and output scoreboard for the randomized phase
  bit   rnd_ready = 1'b0;
  bit   mon_en = 1'b0;
  bit   prev_hold = 1'b0;
  int   prev_data;
  bit   prev_err;
  out_t got_exp;

  always @(posedge clk) begin
    if (rnd_ready) begin
      #2 m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!mon_en || !m_valid) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_data_stable", int'(m_data), prev_data);
        check("hold_err_stable", int'(m_err), int'(prev_err));
      end
      if (m_ready) begin
        prev_hold = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(m_valid), 0);
        end else begin
          got_exp = exp_q.pop_front();
          check("rand_data", int'(m_data), got_exp.data);
          check("rand_err", int'(m_err), int'(got_exp.err));
        end
      end else begin
        prev_hold = 1'b1;
        prev_data = int'(m_data);
        prev_err  = m_err;
      end
    end
  end

  typedef struct {
    logic [6:0] tens;
    logic [6:0] ones;
    int         data;
    bit         err;
  } vec_t;
  vec_t vecs [12];

  initial begin
    bit         d;
    logic [6:0] c;
    int         n;

    vecs[0]  = '{7'h7E, 7'h7E, 0,  1'b0};
    vecs[1]  = '{7'h30, 7'h7B, 19, 1'b0};
    vecs[2]  = '{7'h7B, 7'h7E, 90, 1'b0};
    vecs[3]  = '{7'h5F, 7'h70, 67, 1'b0};
    vecs[4]  = '{7'h7F, 7'h33, 84, 1'b0};
    vecs[5]  = '{7'h79, 7'h5F, 36, 1'b0};
    vecs[6]  = '{7'h00, 7'h30, 0,  1'b1};
    vecs[7]  = '{7'h30, 7'h7F, 18, 1'b0};
    vecs[8]  = '{7'h7E, 7'h7F, 8,  1'b0};
    vecs[9]  = '{7'h30, 7'h31, 0,  1'b1};
    vecs[10] = '{7'h7C, 7'h01, 0,  1'b1};
    vecs[11] = '{7'h7B, 7'h7B, 99, 1'b0};

    // Reset state
    do_reset();
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_err", int'(m_err), 0);
    check("rst_drop_cnt", int'(seq_drop_cnt), 0);
    check("rst_s_ready", int'(s_ready), 1);

    // Basic pair and one-cycle latency
    send(1'b1, 7'h6D);
    check("t1_no_valid_after_tens", int'(m_valid), 0);
    send(1'b0, 7'h5B);
    check("t1_valid", int'(m_valid), 1);
    check("t1_data", int'(m_data), 25);
    check("t1_err", int'(m_err), 0);
    check("t1_s_ready_hold", int'(s_ready), 0);
    handshake("t1");
    check("t1_s_ready_back", int'(s_ready), 1);

    // Back-pressure: value held stable, input blocked
    send(1'b1, 7'h7B);
    send(1'b0, 7'h7B);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid_held", int'(m_valid), 1);
      check("t2_data_held", int'(m_data), 99);
      check("t2_s_ready_low", int'(s_ready), 0);
    end
    handshake("t2");

    // Out-of-order beats
    send(1'b0, 7'h30);
    send(1'b1, 7'h30);
    send(1'b1, 7'h79);
    send(1'b0, 7'h7E);
    check("t3_drop_cnt", int'(seq_drop_cnt), 2);
    check("t3_data", int'(m_data), 30);
    check("t3_err", int'(m_err), 0);
    handshake("t3");

    // Pair table including illegal codes and extremes
    for (int i = 0; i < 12; i++) begin
      send(1'b1, vecs[i].tens);
      send(1'b0, vecs[i].ones);
      check($sformatf("vec%0d_valid", i), int'(m_valid), 1);
      check($sformatf("vec%0d_data", i), int'(m_data), vecs[i].data);
      check($sformatf("vec%0d_err", i), int'(m_err), int'(vecs[i].err));
      handshake($sformatf("vec%0d", i));
    end
    check("table_drop_cnt", int'(seq_drop_cnt), 2);

    // Reset mid-frame discards the stored tens digit
    do_reset();
    send(1'b1, 7'h30);
    do_reset();
    #1 check("t5_s_ready", int'(s_ready), 1);
    send(1'b0, 7'h30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_valid", int'(m_valid), 0);
    end
    check("t5_drop_cnt", int'(seq_drop_cnt), 1);

`ifdef SEG_STABLE_EN
    // Stability filter: only complete runs of identical beats count
    begin
      bit ok;
      do_reset();
      send_raw(1'b1, 7'h33, ok);
      send_raw(1'b1, 7'h33, ok);
      send_raw(1'b1, 7'h5B, ok);
      send_raw(1'b1, 7'h33, ok);
      send_raw(1'b1, 7'h33, ok);
      send_raw(1'b1, 7'h33, ok);
      send_raw(1'b0, 7'h7F, ok);
      send_raw(1'b0, 7'h7F, ok);
      check("t6_no_early_valid", int'(m_valid), 0);
      send_raw(1'b0, 7'h7F, ok);
      check("t6_valid", int'(m_valid), 1);
      check("t6_data", int'(m_data), 48);
      check("t6_drop_cnt", int'(seq_drop_cnt), 0);
      handshake("t6");
      repeat (3) @(negedge clk);
      check("t6_single_output", int'(m_valid), 0);
    end
`endif

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      send(1'b0, codes[1]);
      if (i == CNT_MAX - 2) check("sat_before", int'(seq_drop_cnt), CNT_MAX - 1);
    end
    check("sat_hold", int'(seq_drop_cnt), CNT_MAX);
    send(1'b1, 7'h70);
    send(1'b0, 7'h79);
    check("sat_pair_data", int'(m_data), 73);
    check("sat_still_max", int'(seq_drop_cnt), CNT_MAX);
    handshake("sat");

    // Randomized stream against the model
    do_reset();
    mon_en    = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 9) < 8) ? !mdl_have : mdl_have;
      c = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 9)] : 7'($urandom);
      send(d, c);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rand_drain", exp_q.size(), 0);
    check("rand_drop_cnt", int'(seq_drop_cnt), sat_drops());
    rnd_ready = 1'b0;
    repeat (2) @(negedge clk);
    mon_en  = 1'b0;
    m_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
